y86_fetch_stage: RTL and testbench

// SEQ fetch stage, directly upstream of decode. Owns the architectural PC register
// and splits the current instruction into icode/ifun/rA/rB/valC/valP/stat for decode,

---
 rtl/y86_fetch_stage_if.sv | 28 ++
 rtl/y86_fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_y86_fetch_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/y86_fetch_stage_if.sv
// Interface between the Y86 fetch stage and its environment: the instruction-memory
// bus, the PC-update controls, and the decoded instruction fields sent to later stages.
interface y86_fetch_stage_if;
  logic        pc_we;
  logic [63:0] pc_next;
  logic [63:0] imem_addr;
  logic [79:0] imem_bytes;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retired;

  modport master (
    input  pc_we, pc_next, imem_bytes,
    output imem_addr, pc, icode, ifun, rA, rB, valC, valP, stat, halted, retired
  );

  modport slave (
    output pc_we, pc_next, imem_bytes,
    input  imem_addr, pc, icode, ifun, rA, rB, valC, valP, stat, halted, retired
  );
endinterface

// File: rtl/y86_fetch_stage.sv
// Y86-64 SEQ fetch stage: holds the PC, splits the instruction at the PC into its
// fields, classifies its status and freezes in STOP on any non-AOK completion.
module y86_fetch_stage #(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  y86_fetch_stage_if.master bus
);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_STOP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nxt;
  logic [2:0]  r_stat_q;
  logic [2:0]  w_stat_q_nxt;

  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic [7:0]  w_byte1;
  logic [3:0]  w_len;
  logic [3:0]  w_len_eff;
  logic        w_has_reg;
  logic        w_valc_at1;
  logic        w_valc_at2;
  logic        w_ins;
  logic        w_adr;
  logic [64:0] w_end;
  logic [63:0] w_valc;
  logic [2:0]  w_stat;

  assign w_icode = bus.imem_bytes[7:4];
  assign w_ifun  = bus.imem_bytes[3:0];
  assign w_byte1 = bus.imem_bytes[15:8];

  // Per-icode length, field presence and ifun legality.
  always_comb begin
    w_len      = 4'd1;
    w_has_reg  = 1'b0;
    w_valc_at1 = 1'b0;
    w_valc_at2 = 1'b0;
    w_ins      = 1'b0;
    case (w_icode)
      I_HALT, I_NOP, I_RET: begin
        w_len = 4'd1;
        w_ins = (w_ifun != 4'h0);
      end
      I_CMOV: begin
        w_len     = 4'd2;
        w_has_reg = 1'b1;
        w_ins     = (w_ifun > 4'h6);
      end
      I_OP: begin
        w_len     = 4'd2;
        w_has_reg = 1'b1;
        w_ins     = (w_ifun > 4'h3);
      end
      I_PUSH, I_POP: begin
        w_len     = 4'd2;
        w_has_reg = 1'b1;
        w_ins     = (w_ifun != 4'h0);
      end
      I_JXX: begin
        w_len      = 4'd9;
        w_valc_at1 = 1'b1;
        w_ins      = (w_ifun > 4'h6);
      end
      I_CALL: begin
        w_len      = 4'd9;
        w_valc_at1 = 1'b1;
        w_ins      = (w_ifun != 4'h0);
      end
      I_IRMOV, I_RMMOV, I_MRMOV: begin
        w_len      = 4'd10;
        w_has_reg  = 1'b1;
        w_valc_at2 = 1'b1;
        w_ins      = (w_ifun != 4'h0);
      end
      default: begin
        w_len = 4'd1;
        w_ins = 1'b1;
      end
    endcase
  end

  assign w_len_eff = w_ins ? 4'd1 : w_len;

  always_comb begin
    w_valc = '0;
    if (!w_ins) begin
      if (w_valc_at1)
        w_valc = bus.imem_bytes[71:8];
      else if (w_valc_at2)
        w_valc = bus.imem_bytes[79:16];
    end
  end

  // 65-bit end address so a PC near the top of the address space cannot wrap past the limit.
  assign w_end = {1'b0, r_pc} + {61'b0, w_len_eff};
  assign w_adr = (r_pc >= IMEM_LIMIT) || (w_end > {1'b0, IMEM_LIMIT});

  always_comb begin
    if (w_adr)
      w_stat = STAT_ADR;
    else if (w_ins)
      w_stat = STAT_INS;
    else if (w_icode == I_HALT)
      w_stat = STAT_HLT;
    else
      w_stat = STAT_AOK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_pc      <= PC_RESET;
      r_retired <= '0;
      r_stat_q  <= STAT_AOK;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_retired <= w_retired_nxt;
      r_stat_q  <= w_stat_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    w_stat_q_nxt  = r_stat_q;
    case (r_state)
      S_RUN: begin
        if (bus.pc_we) begin
          if (w_stat == STAT_AOK) begin
            w_pc_nxt      = bus.pc_next;
            w_retired_nxt = r_retired + 32'd1;
          end else begin
            w_stat_q_nxt = w_stat;
            w_state_nxt  = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_state_nxt = S_STOP;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.icode     = w_icode;
  assign bus.ifun      = w_ifun;
  assign bus.rA        = (w_has_reg && !w_ins) ? w_byte1[7:4] : 4'hF;
  assign bus.rB        = (w_has_reg && !w_ins) ? w_byte1[3:0] : 4'hF;
  assign bus.valC      = w_valc;
  assign bus.valP      = r_pc + {60'b0, w_len_eff};
  assign bus.stat      = (r_state == S_STOP) ? r_stat_q : w_stat;
  assign bus.halted    = (r_state == S_STOP);
  assign bus.retired   = r_retired;

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed bench for y86_fetch_stage: decode fields, status classification,
// RUN/STOP behaviour and asynchronous reset.
module tb_y86_fetch_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  localparam logic [79:0] B_IRMOV = 80'h0000_0000_0000_000A_F330;
  localparam logic [79:0] B_CALL  = 80'h0000_0000_0000_0001_0080;
  localparam logic [79:0] B_NOP   = 80'h0000_0000_0000_0000_0010;
  localparam logic [79:0] B_HALT  = 80'h0000_0000_0000_0000_0000;

  y86_fetch_stage_if u_if ();

  y86_fetch_stage #(
    .PC_RESET   (64'h0),
    .IMEM_BYTES (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    u_if.pc_we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic advance(input logic [63:0] nxt);
    @(negedge clk);
    u_if.pc_we   = 1'b1;
    u_if.pc_next = nxt;
    @(posedge clk);
    #1;
    u_if.pc_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    u_if.imem_bytes = B_IRMOV;
    #1;
    if (u_if.pc !== 64'h0) begin $display("FAIL reset_pc got=%h exp=%h", u_if.pc, 64'h0); fails++; end checks++;
    if (u_if.imem_addr !== 64'h0) begin $display("FAIL reset_imem_addr got=%h exp=%h", u_if.imem_addr, 64'h0); fails++; end checks++;
    if (u_if.halted !== 1'b0) begin $display("FAIL reset_halted got=%b exp=0", u_if.halted); fails++; end checks++;
    if (u_if.retired !== 32'd0) begin $display("FAIL reset_retired got=%0d exp=0", u_if.retired); fails++; end checks++;
    if (u_if.icode !== 4'h3) begin $display("FAIL irmov_icode got=%h exp=3", u_if.icode); fails++; end checks++;
    if (u_if.ifun !== 4'h0) begin $display("FAIL irmov_ifun got=%h exp=0", u_if.ifun); fails++; end checks++;
    if (u_if.rA !== 4'hF) begin $display("FAIL irmov_rA got=%h exp=f", u_if.rA); fails++; end checks++;
    if (u_if.rB !== 4'h3) begin $display("FAIL irmov_rB got=%h exp=3", u_if.rB); fails++; end checks++;
    if (u_if.valC !== 64'd10) begin $display("FAIL irmov_valC got=%h exp=%h", u_if.valC, 64'd10); fails++; end checks++;
    if (u_if.valP !== 64'd10) begin $display("FAIL irmov_valP got=%h exp=%h", u_if.valP, 64'd10); fails++; end checks++;
    if (u_if.stat !== 3'd1) begin $display("FAIL irmov_stat got=%0d exp=1", u_if.stat); fails++; end checks++;
  endtask

  task automatic test_call();
    advance(64'h20);
    if (u_if.pc !== 64'h20) begin $display("FAIL adv_pc got=%h exp=%h", u_if.pc, 64'h20); fails++; end checks++;
    if (u_if.retired !== 32'd1) begin $display("FAIL adv_retired got=%0d exp=1", u_if.retired); fails++; end checks++;
    u_if.imem_bytes = B_CALL;
    #1;
    if (u_if.valC !== 64'h100) begin $display("FAIL call_valC got=%h exp=%h", u_if.valC, 64'h100); fails++; end checks++;
    if (u_if.valP !== 64'h29) begin $display("FAIL call_valP got=%h exp=%h", u_if.valP, 64'h29); fails++; end checks++;
    if (u_if.rA !== 4'hF) begin $display("FAIL call_rA got=%h exp=f", u_if.rA); fails++; end checks++;
    if (u_if.stat !== 3'd1) begin $display("FAIL call_stat got=%0d exp=1", u_if.stat); fails++; end checks++;
    advance(64'h100);
    if (u_if.pc !== 64'h100) begin $display("FAIL call_pc got=%h exp=%h", u_if.pc, 64'h100); fails++; end checks++;
    if (u_if.retired !== 32'd2) begin $display("FAIL call_retired got=%0d exp=2", u_if.retired); fails++; end checks++;
  endtask

  task automatic test_halt();
    u_if.imem_bytes = B_HALT;
    #1;
    if (u_if.stat !== 3'd2) begin $display("FAIL halt_stat got=%0d exp=2", u_if.stat); fails++; end checks++;
    if (u_if.halted !== 1'b0) begin $display("FAIL halt_pre_halted got=%b exp=0", u_if.halted); fails++; end checks++;
    if (u_if.valP !== 64'h101) begin $display("FAIL halt_valP got=%h exp=%h", u_if.valP, 64'h101); fails++; end checks++;
    advance(64'h40);
    if (u_if.halted !== 1'b1) begin $display("FAIL halt_halted got=%b exp=1", u_if.halted); fails++; end checks++;
    if (u_if.pc !== 64'h100) begin $display("FAIL halt_pc got=%h exp=%h", u_if.pc, 64'h100); fails++; end checks++;
    if (u_if.retired !== 32'd2) begin $display("FAIL halt_retired got=%0d exp=2", u_if.retired); fails++; end checks++;
    u_if.imem_bytes = B_IRMOV;
    advance(64'h40);
    if (u_if.pc !== 64'h100) begin $display("FAIL stop_pc got=%h exp=%h", u_if.pc, 64'h100); fails++; end checks++;
    if (u_if.retired !== 32'd2) begin $display("FAIL stop_retired got=%0d exp=2", u_if.retired); fails++; end checks++;
    if (u_if.stat !== 3'd2) begin $display("FAIL stop_stat got=%0d exp=2", u_if.stat); fails++; end checks++;
    if (u_if.icode !== 4'h3) begin $display("FAIL stop_icode got=%h exp=3", u_if.icode); fails++; end checks++;
  endtask

  task automatic test_ins();
    do_reset();
    u_if.imem_bytes = 80'h0000_0000_0000_0000_1264;
    #1;
    if (u_if.stat !== 3'd4) begin $display("FAIL op4_stat got=%0d exp=4", u_if.stat); fails++; end checks++;
    if (u_if.valP !== 64'd1) begin $display("FAIL op4_valP got=%h exp=%h", u_if.valP, 64'd1); fails++; end checks++;
    if (u_if.rA !== 4'hF || u_if.rB !== 4'hF) begin $display("FAIL op4_regs got=%h%h exp=ff", u_if.rA, u_if.rB); fails++; end checks++;
    advance(64'h50);
    if (u_if.halted !== 1'b1) begin $display("FAIL ins_halted got=%b exp=1", u_if.halted); fails++; end checks++;
    if (u_if.stat !== 3'd4) begin $display("FAIL ins_stop_stat got=%0d exp=4", u_if.stat); fails++; end checks++;
    if (u_if.pc !== 64'h0) begin $display("FAIL ins_pc got=%h exp=%h", u_if.pc, 64'h0); fails++; end checks++;
    do_reset();
    u_if.imem_bytes = 80'h0000_0000_0000_0000_00C0;
    #1;
    if (u_if.stat !== 3'd4) begin $display("FAIL c0_stat got=%0d exp=4", u_if.stat); fails++; end checks++;
    if (u_if.valP !== 64'd1) begin $display("FAIL c0_valP got=%h exp=%h", u_if.valP, 64'd1); fails++; end checks++;
    u_if.imem_bytes = 80'h0000_0000_0000_0000_1227;
    #1;
    if (u_if.stat !== 3'd4) begin $display("FAIL cmov7_stat got=%0d exp=4", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = 80'h0000_0000_0000_0000_1226;
    #1;
    if (u_if.stat !== 3'd1) begin $display("FAIL cmov6_stat got=%0d exp=1", u_if.stat); fails++; end checks++;
    if (u_if.rA !== 4'h1 || u_if.rB !== 4'h2) begin $display("FAIL cmov6_regs got=%h%h exp=12", u_if.rA, u_if.rB); fails++; end checks++;
    if (u_if.valP !== 64'd2) begin $display("FAIL cmov6_valP got=%h exp=%h", u_if.valP, 64'd2); fails++; end checks++;
    u_if.imem_bytes = 80'h00_1122334455667788_71;
    #1;
    if (u_if.valC !== 64'h1122334455667788) begin $display("FAIL jxx_valC got=%h exp=%h", u_if.valC, 64'h1122334455667788); fails++; end checks++;
    if (u_if.valP !== 64'd9) begin $display("FAIL jxx_valP got=%h exp=%h", u_if.valP, 64'd9); fails++; end checks++;
    u_if.imem_bytes = 80'h0123456789ABCDEF_45_50;
    #1;
    if (u_if.valC !== 64'h0123456789ABCDEF) begin $display("FAIL mrmov_valC got=%h exp=%h", u_if.valC, 64'h0123456789ABCDEF); fails++; end checks++;
    if (u_if.rA !== 4'h4 || u_if.rB !== 4'h5) begin $display("FAIL mrmov_regs got=%h%h exp=45", u_if.rA, u_if.rB); fails++; end checks++;
    if (u_if.valP !== 64'd10) begin $display("FAIL mrmov_valP got=%h exp=%h", u_if.valP, 64'd10); fails++; end checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    u_if.imem_bytes = B_NOP;
    @(negedge clk);
    u_if.pc_we   = 1'b1;
    u_if.pc_next = 64'h4;
    @(posedge clk);
    #1;
    u_if.pc_next = 64'h8;
    @(posedge clk);
    #1;
    u_if.pc_we = 1'b0;
    if (u_if.pc !== 64'h8) begin $display("FAIL b2b_pc got=%h exp=%h", u_if.pc, 64'h8); fails++; end checks++;
    if (u_if.retired !== 32'd2) begin $display("FAIL b2b_retired got=%0d exp=2", u_if.retired); fails++; end checks++;
  endtask

  task automatic test_adr();
    do_reset();
    u_if.imem_bytes = B_NOP;
    advance(64'd1020);
    u_if.imem_bytes = B_IRMOV;
    #1;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr1020_irmov got=%0d exp=3", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = B_NOP;
    #1;
    if (u_if.stat !== 3'd1) begin $display("FAIL adr1020_nop got=%0d exp=1", u_if.stat); fails++; end checks++;
    advance(64'd1022);
    #1;
    if (u_if.stat !== 3'd1) begin $display("FAIL adr1022_nop got=%0d exp=1", u_if.stat); fails++; end checks++;
    if (u_if.valP !== 64'd1023) begin $display("FAIL adr1022_valP got=%0d exp=1023", u_if.valP); fails++; end checks++;
    u_if.imem_bytes = 80'h0000_0000_0000_0000_1260;
    #1;
    if (u_if.stat !== 3'd1) begin $display("FAIL adr1022_op_edge got=%0d exp=1", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = B_IRMOV;
    #1;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr1022_irmov got=%0d exp=3", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = 80'h0000_0000_0000_0000_00C0;
    #1;
    if (u_if.stat !== 3'd4) begin $display("FAIL adr1022_ins got=%0d exp=4", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = B_NOP;
    advance(64'd1024);
    #1;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr1024_nop got=%0d exp=3", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = 80'h0000_0000_0000_0000_00C0;
    #1;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr_over_ins got=%0d exp=3", u_if.stat); fails++; end checks++;
    u_if.imem_bytes = B_HALT;
    #1;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr_over_hlt got=%0d exp=3", u_if.stat); fails++; end checks++;
    advance(64'h0);
    if (u_if.halted !== 1'b1) begin $display("FAIL adr_halted got=%b exp=1", u_if.halted); fails++; end checks++;
    if (u_if.stat !== 3'd3) begin $display("FAIL adr_stop_stat got=%0d exp=3", u_if.stat); fails++; end checks++;
    if (u_if.pc !== 64'd1024) begin $display("FAIL adr_stop_pc got=%0d exp=1024", u_if.pc); fails++; end checks++;
    if (u_if.retired !== 32'd3) begin $display("FAIL adr_retired got=%0d exp=3", u_if.retired); fails++; end checks++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    u_if.imem_bytes = B_NOP;
    u_if.pc_we      = 1'b1;
    u_if.pc_next    = 64'h30;
    rst_n           = 1'b0;
    #1;
    if (u_if.pc !== 64'h0) begin $display("FAIL async_pc got=%h exp=%h", u_if.pc, 64'h0); fails++; end checks++;
    if (u_if.halted !== 1'b0) begin $display("FAIL async_halted got=%b exp=0", u_if.halted); fails++; end checks++;
    if (u_if.retired !== 32'd0) begin $display("FAIL async_retired got=%0d exp=0", u_if.retired); fails++; end checks++;
    if (u_if.stat !== 3'd1) begin $display("FAIL async_stat got=%0d exp=1", u_if.stat); fails++; end checks++;
    @(posedge clk);
    #1;
    if (u_if.pc !== 64'h0) begin $display("FAIL rst_overrides_we got=%h exp=%h", u_if.pc, 64'h0); fails++; end checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    u_if.pc_we = 1'b0;
    if (u_if.pc !== 64'h30) begin $display("FAIL post_rst_pc got=%h exp=%h", u_if.pc, 64'h30); fails++; end checks++;
    if (u_if.retired !== 32'd1) begin $display("FAIL post_rst_retired got=%0d exp=1", u_if.retired); fails++; end checks++;
  endtask

  initial begin
    checks          = 0;
    fails           = 0;
    rst_n           = 1'b0;
    u_if.pc_we      = 1'b0;
    u_if.pc_next    = '0;
    u_if.imem_bytes = '0;
    test_reset();
    test_call();
    test_halt();
    test_ins();
    test_back_to_back();
    test_adr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
